// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Loads one configuration-chain segment serially from its head and returns
//   the bits that fall out of its tail as readback words.
//
// Ports
//   prog_clk, prog_reset_n  clock and synchronous active-low reset
//   start                   begin a load (ignored unless idle)
//   cfg_data/valid/ready    incoming config words, MSB shifted first
//   ccff_head               serial bit driven into the chain head
//   ccff_shift_en           chain advances one position at this edge
//   ccff_tail               bit currently at the chain tail
//   rb_data/valid/ready     readback words, first captured bit in the MSB
//   busy, done              load in progress / one-cycle completion pulse
//   bit_count               bits shifted so far in the current load
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [WORD_W-1:0] sreg;       // outgoing word, MSB is the next head bit
  logic [BW-1:0]     bits_left;  // bits of the current word still to shift
  logic [WORD_W-1:0] cap;        // tail bits collected for the next readback word
  logic [BW-1:0]     cap_cnt;    // number of valid bits in cap
  logic [WORD_W-1:0] cap_sh;
  logic [WORD_W-1:0] move_word;
  logic [CNT_W-1:0]  remaining;
  logic [BW-1:0]     word_bits;
  logic              cap_full, hold_free, stall, move, accept, last_bit;

  always_comb begin
    cap_full      = (cap_cnt == BW'(WORD_W));
    hold_free     = !rb_valid || rb_ready;
    // A full capture register with nowhere to go would lose the next tail bit.
    stall         = cap_full && !hold_free;
    ccff_shift_en = (state == SHIFT) && !stall;
    ccff_head     = ccff_shift_en & sreg[WORD_W-1];
    cfg_ready     = (state == FETCH);
    accept        = cfg_ready && cfg_valid;
    busy          = (state == FETCH) || (state == SHIFT) || (state == FLUSH);
    done          = (state == DONE);
    last_bit      = ccff_shift_en && (bits_left == BW'(1));
    // In FLUSH a partial word is left-aligned so its first captured bit is the MSB.
    move          = hold_free && (cap_full || ((state == FLUSH) && (cap_cnt != '0)));
    move_word     = (state == FLUSH) ? (cap << (BW'(WORD_W) - cap_cnt)) : cap;
    cap_sh        = (cap << 1) | WORD_W'(ccff_tail);
    remaining     = CNT_W'(CHAIN_LEN) - bit_count;
    word_bits     = (remaining < CNT_W'(WORD_W)) ? BW'(remaining) : BW'(WORD_W);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit)
                 state_nxt = ((bit_count + CNT_W'(1)) < CNT_W'(CHAIN_LEN)) ? FETCH : FLUSH;
      // Finish only once nothing is left in capture and the holding word is gone.
      FLUSH:   if ((cap_cnt == '0) && hold_free) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state     <= IDLE;
      bit_count <= '0;
      bits_left <= '0;
      cap_cnt   <= '0;
      rb_valid  <= 1'b0;
      rb_data   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        bit_count <= '0;
        cap_cnt   <= '0;
      end
      if (accept) bits_left <= word_bits;
      if (ccff_shift_en) begin
        bits_left <= bits_left - BW'(1);
        bit_count <= bit_count + CNT_W'(1);
      end
      if (move) begin
        rb_data  <= move_word;
        rb_valid <= 1'b1;
      end else if (rb_valid && rb_ready) begin
        rb_valid <= 1'b0;
      end
      if (ccff_shift_en) begin
        cap_cnt <= move ? BW'(1) : (cap_cnt + BW'(1));
      end else if (move) begin
        cap_cnt <= '0;
      end
    end
  end

  // Datapath registers: their contents only matter when the counters say so.
  always_ff @(posedge prog_clk) begin
    if (accept) sreg <= cfg_data;
    else if (ccff_shift_en) sreg <= sreg << 1;
    if (ccff_shift_en) cap <= move ? WORD_W'(ccff_tail) : cap_sh;
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_valid = 1'b0;
  logic         rb_ready = 1'b1;

  logic         ready_a, head_a, sh_a, tail_a, rbv_a, busy_a, done_a;
  logic [W-1:0] rbd_a;
  logic [15:0]  bc_a;
  logic         ready_b, head_b, sh_b, tail_b, rbv_b, busy_b, done_b;
  logic [W-1:0] rbd_b;
  logic [15:0]  bc_b;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(W), .CNT_W(16)) u_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_a),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
    .ccff_head(head_a), .ccff_shift_en(sh_a), .ccff_tail(tail_a),
    .rb_data(rbd_a), .rb_valid(rbv_a), .rb_ready(rb_ready),
    .busy(busy_a), .done(done_a), .bit_count(bc_a));

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(W), .CNT_W(16)) u_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_b),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
    .ccff_head(head_b), .ccff_shift_en(sh_b), .ccff_tail(tail_b),
    .rb_data(rbd_b), .rb_valid(rbv_b), .rb_ready(rb_ready),
    .busy(busy_b), .done(done_b), .bit_count(bc_b));

  // Behavioural chains: head enters bit 0, tail is the top bit.
  logic [15:0] chain_a = '0;
  logic [11:0] chain_b = '0;
  assign tail_a = chain_a[15];
  assign tail_b = chain_b[11];
  always @(posedge clk) if (sh_a) chain_a <= {chain_a[14:0], head_a};
  always @(posedge clk) if (sh_b) chain_b <= {chain_b[10:0], head_b};

  int sel = 0;
  logic         v_ready, v_head, v_sh, v_rbv, v_busy, v_done;
  logic [W-1:0] v_rbd;
  logic [15:0]  v_bc;
  assign v_ready = (sel == 0) ? ready_a : ready_b;
  assign v_head  = (sel == 0) ? head_a  : head_b;
  assign v_sh    = (sel == 0) ? sh_a    : sh_b;
  assign v_rbv   = (sel == 0) ? rbv_a   : rbv_b;
  assign v_busy  = (sel == 0) ? busy_a  : busy_b;
  assign v_done  = (sel == 0) ? done_a  : done_b;
  assign v_rbd   = (sel == 0) ? rbd_a   : rbd_b;
  assign v_bc    = (sel == 0) ? bc_a    : bc_b;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic mon_en = 1'b0;
  logic         hq[$];
  logic [W-1:0] rq[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: head bits on every shift, readback words on every handshake.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (v_sh) begin
        if (hq.size() == 0) check_eq("head_extra", 32'd1, 32'd0);
        else check_eq("head_bit", {31'd0, v_head}, {31'd0, hq.pop_front()});
      end else if (v_head) begin
        check_eq("head_gated", {31'd0, v_head}, 32'd0);
      end
      if (v_rbv && rb_ready) begin
        if (rq.size() == 0) check_eq("rb_extra", {24'd0, v_rbd}, 32'hFFFF);
        else check_eq("rb_word", {24'd0, v_rbd}, {24'd0, rq.pop_front()});
      end
      if (v_done) done_cnt++;
    end
  end

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, {31'd0, v_ready}, 32'd0);
    check_eq({tag, "_head"},  {31'd0, v_head},  32'd0);
    check_eq({tag, "_shen"},  {31'd0, v_sh},    32'd0);
    check_eq({tag, "_rbv"},   {31'd0, v_rbv},   32'd0);
    check_eq({tag, "_rbd"},   {24'd0, v_rbd},   32'd0);
    check_eq({tag, "_busy"},  {31'd0, v_busy},  32'd0);
    check_eq({tag, "_done"},  {31'd0, v_done},  32'd0);
    check_eq({tag, "_bc"},    {16'd0, v_bc},    32'd0);
  endtask

  // Push expected head stream and readback (old chain contents, first-out bit in MSB).
  task automatic prep(input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [15:0] st;
    logic [15:0] pv;
    int len;
    len = (sel == 0) ? 16 : 12;
    st = {w0, w1};
    for (int i = 15; i >= 16 - len; i--) hq.push_back(st[i]);
    pv = (sel == 0) ? chain_a : {chain_b, 4'b0000};
    rq.push_back(pv[15:8]);
    rq.push_back(pv[7:0]);
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin @(negedge clk); n++; end while (!v_ready && n < 200);
    if (!v_ready) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic present(input logic [W-1:0] w);
    @(posedge clk); #1;
    cfg_data = w;
    cfg_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] w0, input logic [W-1:0] w1, input int gap);
    present(w0);
    if (gap > 0) begin
      wait_ready();
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        check_eq("gap_shen", {31'd0, v_sh}, 32'd0);
        check_eq("gap_bc", {16'd0, v_bc}, 32'd8);
      end
    end
    present(w1);
  endtask

  task automatic wait_bc(input int target);
    int n = 0;
    do begin @(negedge clk); n++; end while (v_bc != 16'(target) && n < 300);
    check_eq("bc_reach", {16'd0, v_bc}, target);
  endtask

  task automatic wait_done(input int len);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin @(negedge clk); n++; end
    check_eq("done_seen", {31'd0, done_cnt > 0}, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("done_once", done_cnt, 32'd1);
    check_eq("final_bc", {16'd0, v_bc}, len);
    check_eq("final_busy", {31'd0, v_busy}, 32'd0);
    check_eq("head_left", hq.size(), 32'd0);
    check_eq("rb_left", rq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 0; check_idle("rst_a");
    sel = 1; check_idle("rst_b");
    sel = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Load into an all-zero chain.
    prep(8'hA5, 8'h3C); pulse_start(); feed(8'hA5, 8'h3C, 0); wait_done(16);
    // Reload: readback returns the previous load.
    prep(8'hFF, 8'h00); pulse_start(); feed(8'hFF, 8'h00, 0); wait_done(16);

    // Twelve-bit chain: partial final word in both directions.
    sel = 1;
    prep(8'hAB, 8'hCD); pulse_start(); feed(8'hAB, 8'hCD, 0); wait_done(12);
    prep(8'h12, 8'h34); pulse_start(); feed(8'h12, 8'h34, 0); wait_done(12);
    sel = 0;

    // Source gap and readback backpressure.
    rb_ready = 1'b0;
    prep(8'h5A, 8'hC3); pulse_start(); feed(8'h5A, 8'hC3, 5);
    wait_bc(16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_shen", {31'd0, v_sh}, 32'd0);
      check_eq("stall_rbv", {31'd0, v_rbv}, 32'd1);
      check_eq("stall_busy", {31'd0, v_busy}, 32'd1);
    end
    @(posedge clk); #1;
    rb_ready = 1'b1;
    wait_done(16);

    // Reset in the middle of a load.
    prep(8'h0F, 8'hF0); pulse_start();
    @(posedge clk); #1;
    cfg_data = 8'h0F;
    cfg_valid = 1'b1;
    wait_bc(5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    mon_en = 1'b0;
    hq.delete();
    rq.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_abort_shen", {31'd0, v_sh}, 32'd0);
    end

    // Start while busy must not restart the count.
    mon_en = 1'b1;
    prep(8'h0F, 8'hF0); pulse_start();
    fork
      feed(8'h0F, 8'hF0, 0);
      begin
        wait_bc(3);
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(negedge clk);
        check_eq("busy_start_bc", {16'd0, v_bc}, 32'd5);
        check_eq("busy_start_busy", {31'd0, v_busy}, 32'd1);
      end
    join
    wait_done(16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
